// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   ST_IDLE / ST_SHIFT / ST_DONE : 2-bit FSM state encoding
//   BCD_DIGIT_W, BCD_MAX_DIGIT   : BCD digit geometry and largest legal digit
//   ADJ_THRESH / ADJ_SUB         : per-digit correction applied after each right shift
//   bin_width(ndigits)           : minimum binary width that holds 10^ndigits-1
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_SUB       = 4'd3;

    function automatic int bin_width(input int ndigits);
        longint max_val;
        int     w;
        max_val = 1;
        for (int i = 0; i < ndigits; i++) begin
            max_val = max_val * 10;
        end
        max_val = max_val - 1;
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if ((64'd1 << i) <= max_val) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction for shift-and-subtract-3 conversion.
//   din  : 4-bit digit after the right shift
//   dout : din - 3 when din >= 8, otherwise din unchanged
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= ADJ_THRESH) ? (din - ADJ_SUB) : din;
    end

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Packed BCD to unsigned binary converter, one result bit per clock.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake, in_bcd sampled on accept only
//   in_bcd               : NDIGITS packed BCD digits, digit 0 in bits [3:0]
//   out_valid / out_ready: output handshake, result held until taken
//   out_bin              : binary result (0 when out_err)
//   out_err              : some input digit was above 9
//   busy                 : conversion in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for input, in_ready=1
// ST_SHIFT | shifting one bit per cycle, BIN_W shifts then DONE
// ST_DONE  | result presented, waiting for out_ready
module bcd_to_bin_conv
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] in_bcd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIN_W-1:0]               out_bin,
    output logic                           out_err,
    output logic                           busy
);

    localparam int BCD_W = BCD_DIGIT_W * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (NDIGITS < 1 || NDIGITS > 9) begin : g_bad_ndigits
        $error("bcd_to_bin_conv: NDIGITS must be in 1..9");
    end
    if (BIN_W < bin_width(NDIGITS)) begin : g_bad_bin_w
        $error("bcd_to_bin_conv: BIN_W too narrow for NDIGITS");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_shr;
    logic [BCD_W-1:0] bcd_adj;
    logic [BIN_W-1:0] bin_reg;
    logic             err_reg;
    logic [CNT_W-1:0] count;
    logic             in_err;
    logic             shift_done;

    assign bcd_shr    = bcd_reg >> 1;
    assign shift_done = (count == CNT_W'(BIN_W - 1));

    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_shr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                in_err = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = in_err ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // datapath: shift registers and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            err_reg <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bcd_reg <= in_bcd;
                        bin_reg <= '0;
                        err_reg <= in_err;
                        count   <= '0;
                    end
                end
                ST_SHIFT: begin
                    bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
                    bcd_reg <= bcd_adj;
                    count   <= count + CNT_W'(1);
                end
                ST_DONE: begin
                    // every BCD bit must have migrated into bin_reg by now
                    assert (err_reg || bcd_reg == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // outputs; the result is gated so partial values never leave the block
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state == ST_SHIFT);
        out_valid = (state == ST_DONE);
        out_err   = out_valid && err_reg;
        out_bin   = (out_valid && !err_reg) ? bin_reg : '0;
    end

endmodule
